// File: rtl/roce_fault_pkg.sv
// Shared definitions for the RoCE TX fault-injection blocks: drop modes,
// FSM state encoding, header widths and the 32-bit Galois LFSR step.
package roce_fault_pkg;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_RANDOM = 2'd1;
  localparam logic [1:0] MODE_PERIOD = 2'd2;
  localparam logic [1:0] MODE_PSN    = 2'd3;

  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  localparam int PSN_WIDTH      = 24;
  localparam int BTH_META_WIDTH = 49;
  localparam int RETH_WIDTH     = 128;
  localparam int IMMDH_WIDTH    = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  function automatic logic [31:0] lfsr32_next(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/roce_packet_dropper_ctrl_if.sv
// RoCE TX bus between the header/payload generator and the UDP/IP stack:
// BTH, optional RETH/IMMDH headers, packed eth/ip/udp fields and the payload stream.
interface roce_packet_dropper_ctrl_if
  import roce_fault_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int META_WIDTH = 377
);
  // Every channel transfers on a clock edge where valid and ready are both high;
  // a source holds valid and its data stable until that edge, and ready may depend on valid.
  logic                      bth_valid;
  logic                      bth_ready;
  logic [PSN_WIDTH-1:0]      bth_psn;
  logic [BTH_META_WIDTH-1:0] bth_meta;
  logic                      reth_valid;
  logic                      reth_ready;
  logic [RETH_WIDTH-1:0]     reth_data;
  logic                      immdh_valid;
  logic                      immdh_ready;
  logic [IMMDH_WIDTH-1:0]    immdh_data;
  logic [META_WIDTH-1:0]     hdr_meta;
  logic [DATA_WIDTH-1:0]     tdata;
  logic [DATA_WIDTH/8-1:0]   tkeep;
  logic                      tvalid;
  logic                      tready;
  logic                      tlast;
  logic                      tuser;

  modport master (
    output bth_valid, bth_psn, bth_meta, reth_valid, reth_data,
           immdh_valid, immdh_data, hdr_meta, tdata, tkeep, tvalid, tlast, tuser,
    input  bth_ready, reth_ready, immdh_ready, tready
  );

  modport slave (
    input  bth_valid, bth_psn, bth_meta, reth_valid, reth_data,
           immdh_valid, immdh_data, hdr_meta, tdata, tkeep, tvalid, tlast, tuser,
    output bth_ready, reth_ready, immdh_ready, tready
  );

endinterface

// File: rtl/roce_lfsr32.sv
// Seedable 32-bit Galois LFSR that steps once per cycle while advance is high.
module roce_lfsr32
  import roce_fault_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  output logic [31:0] value
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= SEED;
    end else if (advance) begin
      value <= lfsr32_next(value);
    end
  end

endmodule

// File: rtl/roce_packet_dropper_ctrl.sv
// Fault-injection stage in the RoCE TX path: one drop decision per packet, then
// the packet is either marked bad on its last beat or swallowed entirely.
module roce_packet_dropper_ctrl
  import roce_fault_pkg::*;
#(
  parameter int          DATA_WIDTH = 64,
  parameter int          META_WIDTH = 377,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_2468,
  parameter int          CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           cfg_mode,
  input  logic                 cfg_discard,
  input  logic [31:0]          cfg_threshold,
  input  logic [15:0]          cfg_period,
  input  logic [23:0]          cfg_psn,
  roce_packet_dropper_ctrl_if.slave  s,
  roce_packet_dropper_ctrl_if.master m,
  output logic [CNT_WIDTH-1:0] stat_pkts,
  output logic [CNT_WIDTH-1:0] stat_drops,
  output state_t               dbg_state,
  output logic [31:0]          dbg_lfsr
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic                  drop_q;
  logic [15:0]           period_cnt;
  logic [31:0]           lfsr;
  logic                  period_hit;
  logic                  drop_now;
  logic                  discard_now;
  logic                  bth_hs;
  logic [DATA_WIDTH-1:0] tdata_w;
  logic [META_WIDTH-1:0] meta_w;
  logic                  unused_hdr_ready;

  // Headers and payload data are never modified; only valids, readys and tuser are steered.
  assign m.bth_psn    = s.bth_psn;
  assign m.bth_meta   = s.bth_meta;
  assign m.reth_data  = s.reth_data;
  assign m.immdh_data = s.immdh_data;
  assign meta_w       = s.hdr_meta;
  assign m.hdr_meta   = meta_w;
  assign tdata_w      = s.tdata;
  assign m.tdata      = tdata_w;
  assign m.tkeep      = s.tkeep;
  assign m.tlast      = s.tlast;

  // RETH/IMMDH travel with the BTH, so the BTH ready is the only downstream ready consulted.
  assign unused_hdr_ready = m.reth_ready ^ m.immdh_ready;

  // A period of 0 or 1 drops every packet; >= recovers if the period shrinks under the count.
  assign period_hit = (cfg_period <= 16'd1) || (period_cnt >= cfg_period - 16'd1);

  always_comb begin
    drop_now = 1'b0;
    case (cfg_mode)
      MODE_OFF:    drop_now = 1'b0;
      MODE_RANDOM: drop_now = (lfsr < cfg_threshold);
      MODE_PERIOD: drop_now = period_hit;
      MODE_PSN:    drop_now = (s.bth_psn == cfg_psn);
      default:     drop_now = 1'b0;
    endcase
  end

  assign discard_now = drop_now & cfg_discard;
  assign bth_hs      = rst_n && (state_q == ST_IDLE) && s.bth_valid
                       && (discard_now || m.bth_ready);

  always_comb begin
    state_d       = state_q;
    m.bth_valid   = 1'b0;
    m.reth_valid  = 1'b0;
    m.immdh_valid = 1'b0;
    s.bth_ready   = 1'b0;
    s.reth_ready  = 1'b0;
    s.immdh_ready = 1'b0;
    m.tvalid      = 1'b0;
    s.tready      = 1'b0;
    m.tuser       = s.tuser;
    case (state_q)
      ST_IDLE: begin
        if (discard_now) begin
          s.bth_ready   = 1'b1;
          s.reth_ready  = 1'b1;
          s.immdh_ready = 1'b1;
        end else begin
          m.bth_valid   = s.bth_valid;
          m.reth_valid  = s.reth_valid;
          m.immdh_valid = s.immdh_valid;
          s.bth_ready   = m.bth_ready;
          s.reth_ready  = m.bth_ready;
          s.immdh_ready = m.bth_ready;
        end
        if (bth_hs) begin
          state_d = discard_now ? ST_DROP : ST_PASS;
        end
      end
      ST_PASS: begin
        m.tvalid = s.tvalid;
        s.tready = m.tready;
        m.tuser  = s.tuser | (s.tlast & drop_q);
        if (s.tvalid && m.tready && s.tlast) begin
          state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        s.tready = 1'b1;
        if (s.tvalid && s.tlast) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!rst_n) begin
      m.bth_valid   = 1'b0;
      m.reth_valid  = 1'b0;
      m.immdh_valid = 1'b0;
      s.bth_ready   = 1'b0;
      s.reth_ready  = 1'b0;
      s.immdh_ready = 1'b0;
      m.tvalid      = 1'b0;
      s.tready      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      drop_q     <= 1'b0;
      period_cnt <= 16'd0;
      stat_pkts  <= '0;
      stat_drops <= '0;
    end else begin
      state_q <= state_d;
      if (bth_hs) begin
        drop_q <= drop_now;
        if (cfg_mode == MODE_PERIOD) begin
          period_cnt <= period_hit ? 16'd0 : period_cnt + 16'd1;
        end
        if (stat_pkts != '1) begin
          stat_pkts <= stat_pkts + CNT_ONE;
        end
        if (drop_now && (stat_drops != '1)) begin
          stat_drops <= stat_drops + CNT_ONE;
        end
      end
    end
  end

  roce_lfsr32 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (bth_hs),
    .value   (lfsr)
  );

  assign dbg_state = state_q;
  assign dbg_lfsr  = lfsr;

endmodule

// File: doc/roce_packet_dropper_ctrl.md
Name: roce_packet_dropper_ctrl

Overview:
Configurable fault-injection stage placed in the RoCE TX path between the RoCE header/payload generator and the UDP/IP stack, used to exercise retransmission logic.
- Makes one drop decision per packet, from a seedable LFSR, a periodic counter or a PSN match.
- Either marks the packet bad (tuser on tlast) or fully discards its headers and payload.
- Keeps saturating statistics counters.

Parameters:
DATA_WIDTH, 64, payload tdata width; tkeep is DATA_WIDTH/8.
META_WIDTH, 377, packed eth/ip/udp header fields, passed through untouched.
LFSR_SEED, 32'hACE1_2468, LFSR reset value; must be nonzero.
CNT_WIDTH, 32, statistics counter width.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cfg_mode  in  2  0 off, 1 random, 2 every-Nth, 3 PSN match
cfg_discard  in  1  0 mark tuser, 1 discard packet
cfg_threshold  in  32  random mode: drop when lfsr < cfg_threshold
cfg_period  in  16  every-Nth mode: N; 0 or 1 drops every packet
cfg_psn  in  24  PSN-match mode: target PSN
s_roce_bth_valid / s_roce_bth_ready  in/out  1/1  BTH handshake
s_roce_bth_psn  in  24  PSN
s_roce_bth_meta  in  49  op_code, p_key, dest_qp, ack_req
s_roce_reth_valid / s_roce_reth_ready  in/out  1/1  RETH handshake
s_roce_reth_data  in  128  v_addr, r_key, length
s_roce_immdh_valid / s_roce_immdh_ready  in/out  1/1  IMMDH handshake
s_roce_immdh_data  in  32  immediate
s_hdr_meta  in  META_WIDTH  eth/ip/udp fields
s_roce_payload_axis_{tdata,tkeep,tvalid,tready,tlast,tuser}  in/out  DATA_WIDTH/DATA_WIDTH/8/1/1/1/1  payload
m_* mirror of every s_* above  opposite direction  same widths  output side
stat_pkts  out  CNT_WIDTH  BTH handshakes seen
stat_drops  out  CNT_WIDTH  packets marked or discarded

Behaviour:
Reset (rst_n low at posedge):
- State IDLE; lfsr = LFSR_SEED; period_cnt = 0; stats = 0; drop_q = 0.
- All m_*_valid and all s_*_ready low. Data outputs are don't-care.

States:
- IDLE: header acceptance.
- PASS: forward payload.
- DROP: swallow payload.
- One packet in flight; a new BTH is accepted only in IDLE.

Combinational decision in IDLE (drop_now):
- mode 0: 0.
- mode 1: lfsr < cfg_threshold (unsigned). 0 never drops; 32'hFFFF_FFFF drops all but lfsr == 32'hFFFF_FFFF.
- mode 2: period_cnt == cfg_period-1 (period_cnt only counts in mode 2). cfg_period 0 or 1 means drop every packet.
- mode 3: s_roce_bth_psn == cfg_psn.

Headers:
- RETH and IMMDH valids, when present, are asserted in the same cycle as BTH valid and handshake together with it.

IDLE, pass case (!(drop_now & cfg_discard)):
- m_*_valid = s_*_valid; s_*_ready = m_roce_bth_ready.
- All header data combinational pass-through; zero latency.

IDLE, discard case (drop_now & cfg_discard):
- m_*_valid = 0; s_*_ready = 1.

On BTH handshake:
- lfsr advances one step: Galois, taps 32,22,2,1.
- period_cnt increments, wrapping to 0 at cfg_period-1.
- stat_pkts increments; stat_drops increments if drop_now.
- drop_q <= drop_now.
- Next state: DROP if drop_now & cfg_discard, else PASS.

PASS:
- Payload pass-through; m_tuser = s_tuser | (s_tlast & drop_q).
- Return to IDLE on tlast handshake.

DROP:
- s_tready = 1; m_tvalid = 0.
- Return to IDLE on tlast handshake.

Payload rules:
- Payload ready/valid held low in IDLE.
- A single-beat packet (tlast on first beat) returns to IDLE the cycle after its tlast.

Config:
- cfg_* changes are sampled only in IDLE. Changing mode or period mid-packet affects the next packet only.

Counters:
- Saturate at all-ones; no wrap.

Reset mid-packet:
- Immediate return to IDLE; the partial packet is abandoned. The upstream must also be reset.

Decomposition:
- Shared package roce_fault_pkg: mode encodings (MODE_OFF, MODE_RANDOM, MODE_PERIOD, MODE_PSN), LFSR tap constant, BTH_META_WIDTH = 49, RETH_WIDTH = 128.
- Sub-module roce_lfsr32: seed parameter, advance enable, current value output. Reusable by other fault-injection blocks.

Test Plan:
- mode 0, 10 packets of 4 beats, sink always ready -> output identical to input; stat_pkts = 10, stat_drops = 0, no tuser set.
- mode 2, period 3, mark, 9 packets -> packets 3, 6, 9 have tuser = 1 on tlast only; stat_drops = 3.
- mode 3, cfg_psn = 0x000005, discard, PSNs 0..9 -> PSN 5 absent (no bth/reth/payload beats), others intact; upstream never stalls on PSN 5.
- mode 1, threshold 0x8000_0000, 1000 packets, seed default -> stat_drops matches a reference LFSR model exactly; threshold 0 gives 0 drops.
- Backpressure: m_tready toggling 50% in PASS and a single-beat discarded packet -> no beat lost or duplicated; return to IDLE one cycle after tlast.
- rst_n low for 1 cycle mid-payload in DROP -> next cycle all valids/readys low, stats 0, lfsr = LFSR_SEED.
